// File: rtl/mux_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// mux_scan_if
// Bundle between the scan sequencer and the rest of the system: scan control,
// the 4:1 mux select/output pair, and the valid/ready frame port.
//
//   start        : begin a scan (seen only while the sequencer is idle)
//   continuous   : restart immediately after a frame completes
//   sel          : select lines to the 4:1 mux (00=a, 01=b, 10=c, 11=d)
//   mux_y        : mux output, synchronous to clk
//   frame        : completed frame, bit k = sample of channel k
//   frame_valid  : frame holds an unconsumed result
//   frame_ready  : consumer takes frame on an edge with frame_valid=1
//   busy         : a scan is in progress
//   overrun      : sticky, a completed frame was dropped
//   clr_overrun  : clears overrun
//
// master = sequencer side, slave = controller/consumer/mux side.
// ---------------------------------------------------------------------------
interface mux_scan_if;
   logic       start;
   logic       continuous;
   logic [1:0] sel;
   logic       mux_y;
   logic [3:0] frame;
   logic       frame_valid;
   logic       frame_ready;
   logic       busy;
   logic       overrun;
   logic       clr_overrun;

   modport master (
      input  start, continuous, mux_y, frame_ready, clr_overrun,
      output sel, frame, frame_valid, busy, overrun
   );

   modport slave (
      output start, continuous, mux_y, frame_ready, clr_overrun,
      input  sel, frame, frame_valid, busy, overrun
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
// Steps the select of a 4:1 mux through channels 0..3, holds each channel for
// SETTLE_CYCLES clocks, samples the mux output at the end of the hold, and
// packs the four samples into a 4-bit frame on a valid/ready port. Supports
// single-shot and continuous scanning; a frame that completes while the
// previous one is still unconsumed is dropped and flagged in sticky overrun.
//
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mux_scan_if.master (scan control, mux select/output, frame port)
//
// SETTLE_CYCLES : hold time per channel in clocks, 1..255
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   mux_scan_if.master    bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   logic [0:0] state_q,  state_d;
   logic [7:0] cnt_q,    cnt_d;
   logic [1:0] sel_q,    sel_d;
   logic [2:0] shadow_q, shadow_d;
   logic [3:0] frame_q,  frame_d;
   logic       fv_q,     fv_d;
   logic       ovr_q,    ovr_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      fv_d     = fv_q;
      ovr_d    = ovr_q;

      // Consumer handshake; a frame load later in this block overrides it,
      // which keeps frame_valid high across a simultaneous accept and load.
      if (fv_q && bus.frame_ready) begin
         fv_d = 1'b0;
      end

      // Clear first so that a same-edge overrun set below wins.
      if (bus.clr_overrun) begin
         ovr_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            sel_d = 2'd0;
            cnt_d = 8'd0;
            if (bus.start) begin
               state_d = ST_SCAN;
            end
         end

         default: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = 8'd0;
               if (sel_q != 2'd3) begin
                  case (sel_q)
                     2'd0:    shadow_d[0] = bus.mux_y;
                     2'd1:    shadow_d[1] = bus.mux_y;
                     default: shadow_d[2] = bus.mux_y;
                  endcase
                  sel_d = sel_q + 2'd1;
               end else begin
                  // Channel 3 goes straight into the frame; no shadow bit needed.
                  if (!fv_q || bus.frame_ready) begin
                     frame_d = {bus.mux_y, shadow_q};
                     fv_d    = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
                  sel_d = 2'd0;
                  if (!bus.continuous) begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         sel_q    <= 2'd0;
         shadow_q <= 3'd0;
         frame_q  <= 4'd0;
         fv_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
         ovr_q    <= ovr_d;
      end
   end

   assign bus.sel         = sel_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = fv_q;
   assign bus.busy        = (state_q == ST_SCAN);
   assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Bench for mux_scan_sequencer: dut_a uses the default settle time of 2,
// dut_b uses a settle time of 1. A small 4:1 mux model feeds both from the
// shared mux_in vector (bit0=a, bit1=b, bit2=c, bit3=d).
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] mux_in = 4'd0;

   mux_scan_if ifa();
   mux_scan_if ifb();

   assign ifa.mux_y = mux_in[ifa.sel];
   assign ifb.mux_y = mux_in[ifb.sel];

   mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mux_in;
      logic [3:0] exp_frame;
      int         exp_lat;
   } vec_t;

   vec_t       vecs [5];
   logic [3:0] sb_q [$];
   int         total_cnt = 0;
   int         pass_cnt  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_frame(input string name, input logic [3:0] act);
      logic [3:0] e;
      if (sb_q.size() == 0) begin
         total_cnt++;
         $display("FAIL %s: got %0h expected <scoreboard empty>", name, act);
      end else begin
         e = sb_q.pop_front();
         chk(name, 16'(act), 16'(e));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] outs_a();
      return 16'({ifa.sel, ifa.frame, ifa.frame_valid, ifa.busy, ifa.overrun});
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic bad;

      vecs[0] = '{4'b1101, 4'b1101, 8};
      vecs[1] = '{4'b0000, 4'b0000, 8};
      vecs[2] = '{4'b1111, 4'b1111, 8};
      vecs[3] = '{4'b0110, 4'b0110, 8};
      vecs[4] = '{4'b1001, 4'b1001, 8};

      ifa.start = 1'b0; ifa.continuous = 1'b0; ifa.frame_ready = 1'b0; ifa.clr_overrun = 1'b0;
      ifb.start = 1'b0; ifb.continuous = 1'b0; ifb.frame_ready = 1'b0; ifb.clr_overrun = 1'b0;

      // Reset then idle
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("reset_idle", outs_a(), 16'd0);
      end

      // Single-shot scans, table driven
      for (int i = 0; i < 5; i++) begin
         mux_in = vecs[i].mux_in;
         sb_q.push_back(vecs[i].exp_frame);
         ifa.start = 1'b1;
         tick();
         ifa.start = 1'b0;
         n = 0;
         while (!ifa.frame_valid && n < 50) begin
            if (i == 0 && n < 8) chk("sel_step", 16'(ifa.sel), 16'(n / 2));
            tick();
            n++;
         end
         chk("latency", 16'(n), 16'(vecs[i].exp_lat));
         check_frame("single_frame", ifa.frame);
         chk("busy_after", 16'(ifa.busy), 16'd0);
         chk("sel_after", 16'(ifa.sel), 16'd0);
         if (i == 0) begin
            bad = 1'b0;
            for (int k = 0; k < 10; k++) begin
               tick();
               if (!(ifa.frame_valid === 1'b1 && ifa.frame === 4'b1101)) bad = 1'b1;
            end
            chk("frame_hold", 16'(bad), 16'd0);
            ifa.frame_ready = 1'b1;
            tick();
            chk("accept_drop", 16'(ifa.frame_valid), 16'd0);
            ifa.frame_ready = 1'b0;
         end else begin
            ifa.frame_ready = 1'b1;
            tick();
            ifa.frame_ready = 1'b0;
         end
      end

      // Continuous with accept coinciding with load
      ifa.continuous = 1'b1;
      mux_in = 4'b1011;
      sb_q.push_back(4'b1011);
      sb_q.push_back(4'b0110);
      sb_q.push_back(4'b0110);
      sb_q.push_back(4'b0110);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         case (k)
            8: begin
               chk("cont_v0", 16'(ifa.frame_valid), 16'd1);
               check_frame("cont_f0", ifa.frame);
               mux_in = 4'b0110;
            end
            15: begin
               chk("cont_hold", 16'({ifa.frame_valid, ifa.frame}), 16'h1b);
               ifa.frame_ready = 1'b1;
            end
            16: begin
               chk("cont_swap_valid", 16'(ifa.frame_valid), 16'd1);
               check_frame("cont_f1", ifa.frame);
               chk("cont_ovr", 16'(ifa.overrun), 16'd0);
            end
            17: chk("cont_accept", 16'(ifa.frame_valid), 16'd0);
            24: begin
               chk("cont_v2", 16'(ifa.frame_valid), 16'd1);
               check_frame("cont_f2", ifa.frame);
               ifa.continuous = 1'b0;
            end
            32: begin
               chk("cont_end_busy", 16'(ifa.busy), 16'd0);
               chk("cont_v3", 16'(ifa.frame_valid), 16'd1);
               check_frame("cont_f3", ifa.frame);
               chk("cont_ovr_end", 16'(ifa.overrun), 16'd0);
            end
            default: ;
         endcase
      end
      tick();
      chk("cont_final_accept", 16'(ifa.frame_valid), 16'd0);
      ifa.frame_ready = 1'b0;

      // Overrun: sticky, clear, re-set, set beats clear
      ifa.continuous = 1'b1;
      mux_in = 4'b1001;
      sb_q.push_back(4'b1001);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         tick();
         case (k)
            8: begin
               check_frame("ovr_f0", ifa.frame);
               chk("ovr_none", 16'(ifa.overrun), 16'd0);
               mux_in = 4'b0101;
            end
            16: begin
               chk("ovr_set", 16'(ifa.overrun), 16'd1);
               chk("ovr_keep_frame", 16'({ifa.frame_valid, ifa.frame}), 16'h19);
               ifa.clr_overrun = 1'b1;
            end
            17: begin
               chk("ovr_clear", 16'(ifa.overrun), 16'd0);
               ifa.clr_overrun = 1'b0;
            end
            24: begin
               chk("ovr_reset_again", 16'(ifa.overrun), 16'd1);
               chk("ovr_keep_frame2", 16'(ifa.frame), 16'h9);
            end
            31: ifa.clr_overrun = 1'b1;
            32: begin
               chk("ovr_set_wins", 16'(ifa.overrun), 16'd1);
               ifa.clr_overrun = 1'b0;
            end
            33: chk("ovr_sticky", 16'(ifa.overrun), 16'd1);
            default: ;
         endcase
      end
      #2 rst = 1'b1;
      #1 chk("ovr_async_reset", outs_a(), 16'd0);
      ifa.continuous = 1'b0;
      tick();
      rst = 1'b0;

      // Reset mid-scan
      mux_in = 4'b1101;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      n = 0;
      while (ifa.sel != 2'd2 && n < 20) begin
         tick();
         n++;
      end
      chk("mid_reach_sel2", 16'(ifa.sel), 16'd2);
      #2 rst = 1'b1;
      #1 chk("mid_async", outs_a(), 16'd0);
      tick(); tick();
      rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ifa.frame_valid !== 1'b0 || ifa.busy !== 1'b0) bad = 1'b1;
      end
      chk("mid_no_resume", 16'(bad), 16'd0);
      mux_in = 4'b0011;
      sb_q.push_back(4'b0011);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      n = 0;
      while (!ifa.frame_valid && n < 50) begin
         tick();
         n++;
      end
      chk("mid_latency", 16'(n), 16'd8);
      check_frame("mid_frame", ifa.frame);
      ifa.frame_ready = 1'b1;
      tick();
      ifa.frame_ready = 1'b0;

      // Boundary: settle of 1, start held high throughout
      mux_in = 4'b1010;
      ifb.start = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("bnd_sel", 16'(ifb.sel), 16'(k));
         chk("bnd_busy", 16'(ifb.busy), 16'd1);
         tick();
      end
      chk("bnd_valid", 16'(ifb.frame_valid), 16'd1);
      chk("bnd_frame", 16'(ifb.frame), 16'ha);
      chk("bnd_idle", 16'({ifb.busy, ifb.sel}), 16'd0);
      tick();
      chk("bnd_restart", 16'({ifb.busy, ifb.sel}), 16'h4);
      tick();
      chk("bnd_sel_restart", 16'(ifb.sel), 16'd1);
      mux_in = 4'b0101;
      tick(); tick(); tick();
      ifb.start = 1'b0;
      chk("bnd_ovr", 16'(ifb.overrun), 16'd1);
      chk("bnd_keep", 16'({ifb.frame_valid, ifb.frame}), 16'h1a);
      tick();
      chk("bnd_stop", 16'(ifb.busy), 16'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the team's 4:1 select mux (inputs a/b/c/d, 2-bit select s, output y).
- Drives the mux select through channels 0..3 in order. Waits a programmable settle time on each channel, then samples the mux output.
- Packs the four samples into a 4-bit frame and presents it on a valid/ready output port.
- Supports single-shot and continuous scanning, with overrun detection.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each channel is held before its sample is taken; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  when 1 at the channel-3 sample edge, the next scan starts immediately.
- sel  output  2  drives the mux select s; 00 selects a, 01 b, 10 c, 11 d.
- mux_y  input  1  mux output y.
- frame  output  4  completed frame; bit k is the sample of channel k.
- frame_valid  output  1  frame holds an unconsumed result.
- frame_ready  input  1  consumer accepts frame on an edge where frame_valid=1.
- busy  output  1  a scan is in progress.
- overrun  output  1  sticky; a completed frame was dropped.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset: rst=1 forces, asynchronously, sel=0, frame=0, frame_valid=0, busy=0, overrun=0, settle counter=0, shadow register=0, state=IDLE. A partial frame in progress is discarded. Scanning does not resume after reset is released.
- States: IDLE and SCAN.
- IDLE:
  - sel=0, busy=0.
  - On an edge with start=1: go to SCAN, sel=0, cnt=0, busy=1.
- SCAN:
  - cnt increments each edge.
  - On the edge where cnt==SETTLE_CYCLES-1: shadow[sel] <= mux_y, cnt <= 0.
  - If sel<3 on that edge, sel increments.
  - If sel==3 on that edge, the frame completes (see below).
  - start is ignored while in SCAN.
- Timing: start is seen at edge E0. Channel k is sampled at edge E0+(k+1)*SETTLE_CYCLES. frame_valid first rises after edge E0+4*SETTLE_CYCLES (8 cycles with the default).
- Frame completion, on the channel-3 sample edge:
  - The completed value is {mux_y, shadow[2:0]}.
  - If frame_valid=0, or frame_valid=1 and frame_ready=1 on this same edge: load frame with the completed value and set frame_valid=1.
  - Otherwise (frame_valid=1, frame_ready=0): keep the old frame, drop the new one, set overrun=1.
  - Then, if continuous=1: stay in SCAN with sel=0, cnt=0. If continuous=0: go to IDLE, busy=0.
- Output handshake:
  - frame and frame_valid stay stable until an edge with frame_valid=1 and frame_ready=1.
  - On that edge frame_valid drops to 0, unless the same edge loads a new frame.
  - frame_ready while frame_valid=0 has no effect.
  - start in IDLE is permitted while frame_valid=1 is still pending.
- Overrun:
  - Sticky; cleared on an edge with clr_overrun=1.
  - If a set and a clear occur on the same edge, set wins.
- The sel output is registered and is glitch-free between edges.
- mux_y is assumed synchronous to clk; no synchroniser is included.

Test Plan:
- Reset then idle: rst pulse with start=0 -> sel=0, frame=0, frame_valid=0, busy=0, overrun=0, held for 20 cycles.
- Single-shot scan: SETTLE_CYCLES=2, mux inputs a=1 b=0 c=1 d=1, start pulse, frame_ready=0 -> sel steps 0,1,2,3 every 2 cycles; frame_valid=1 with frame=4'b1101 after 8 edges; busy=0 afterwards; frame held 10 cycles until frame_ready=1, then frame_valid=0 on the next edge.
- Continuous with back-to-back accept: continuous=1, frame_ready=1, inputs changed to 4'b0110 mid-run -> frames arrive every 8 cycles with no gap; frame_valid stays 1 across the accept/load edge; the frame after the change reads 4'b0110; overrun=0.
- Overrun: continuous=1, frame_ready=0 -> first frame is held unchanged; overrun=1 at the second completion edge; clr_overrun pulse clears it; it sets again on the next completion edge.
- Reset mid-scan: assert rst at sel=2 -> all outputs return to reset values immediately (asynchronously); no frame_valid after rst is released; a new start gives a correct full frame.
- Boundary: SETTLE_CYCLES=1, and start held high for the whole scan -> sel changes every cycle; frame_valid after 4 edges; start is ignored during SCAN; with continuous=0 the scan restarts on the edge after IDLE is reached while start is still high.
